// File: rtl/rmst_pkg.sv
// Shared definitions for the Avalon-MM read master: FSM state encoding,
// default word geometry and the byteenable pattern.
package rmst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rmst_state_t;

    localparam int RMST_XDW = 128;
    localparam int RMST_BPW = RMST_XDW / 8;
    localparam logic [RMST_BPW-1:0] RMST_BYTEENABLE = '1;

    // Bytes per bus word for a given data width.
    function automatic int rmst_bpw(input int xdw);
        return xdw / 8;
    endfunction

endpackage

// File: rtl/avalon_read_master_if.sv
// Avalon-MM read bus between the read master (initiator) and the memory
// fabric (slave).
interface avalon_read_master_if #(
    parameter int XAW = 32,
    parameter int XDW = 128
);
    logic [XAW-1:0]   master_address;
    logic             master_read;
    logic [XDW/8-1:0] master_byteenable;
    logic [XDW-1:0]   master_readdata;
    logic             master_readdatavalid;
    logic             master_waitrequest;

    modport master (
        output master_address,
        output master_read,
        output master_byteenable,
        input  master_readdata,
        input  master_readdatavalid,
        input  master_waitrequest
    );

    modport slave (
        input  master_address,
        input  master_read,
        input  master_byteenable,
        output master_readdata,
        output master_readdatavalid,
        output master_waitrequest
    );
endinterface

// File: rtl/rmst_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; the head word is
// presented combinationally and reads as zero while empty.
module rmst_sync_fifo #(
    parameter int DW    = 128,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          not_empty,
    output logic [AW:0]   used
);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   USED_ONE = (AW+1)'(1);
    localparam logic [AW:0]   USED_MAX = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   used_reg;
    logic          push;
    logic          pop;

    assign not_empty = (used_reg != '0);
    assign push      = wr_en && (used_reg != USED_MAX);
    assign pop       = rd_en && not_empty;
    assign used      = used_reg;
    assign rd_data   = not_empty ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            used_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                used_reg <= used_reg + USED_ONE;
            end else if (pop && !push) begin
                used_reg <= used_reg - USED_ONE;
            end
        end
    end

endmodule

// File: rtl/avalon_read_master.sv
// Avalon-MM pipelined single-word read master with credit-limited issue into
// a show-ahead FIFO. Define RMST_FIXED_LOCATION_EN to honour control_fixed_location.
module avalon_read_master
    import rmst_pkg::*;
#(
    parameter int XAW        = 32,
    parameter int XDW        = 128,
    parameter int FIFO_DEPTH = 32,
    parameter int FAW        = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           control_fixed_location,
    input  logic [XAW-1:0] control_read_base,
    input  logic [XAW-1:0] control_read_length,
    input  logic           control_go,
    output logic           control_done,
    input  logic           user_read_buffer,
    output logic [XDW-1:0] user_buffer_data,
    output logic           user_data_available,
    avalon_read_master_if.master bus
);
    localparam int             BPW      = rmst_bpw(XDW);
    localparam logic [XAW-1:0] BPW_STEP = XAW'(BPW);
    localparam logic [FAW:0]   PEND_ONE = (FAW+1)'(1);
    localparam logic [FAW+1:0] CREDITS  = (FAW+2)'(FIFO_DEPTH);

    rmst_state_t    state_reg;
    logic [XAW-1:0] addr_reg;
    logic [XAW-1:0] remaining_reg;
    logic [FAW:0]   pending_reg;
    logic [FAW:0]   pending_next;
    logic           zero_done_reg;
    logic [XAW-1:0] addr_step;

    logic [FAW:0]   fifo_used;
    logic [FAW+1:0] in_use;
    logic           credit_ok;
    logic           read_req;
    logic           accept;
    logic           rsp_valid;
    logic           drain_done;

`ifdef RMST_FIXED_LOCATION_EN
    logic fixed_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fixed_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && control_go) begin
            fixed_reg <= control_fixed_location;
        end
    end

    assign addr_step = fixed_reg ? '0 : BPW_STEP;
`else
    logic unused_fixed_location;
    assign unused_fixed_location = control_fixed_location;
    assign addr_step = BPW_STEP;
`endif

    // Every word already requested or still buffered holds a FIFO slot, so
    // issue stops before the FIFO could overflow.
    assign in_use    = {1'b0, fifo_used} + {1'b0, pending_reg};
    assign credit_ok = (in_use < CREDITS);
    assign read_req  = (state_reg == ST_READ) && (remaining_reg != '0) && credit_ok;
    assign accept    = read_req && !bus.master_waitrequest;

    // Responses with nothing outstanding belong to a transfer aborted by reset.
    assign rsp_valid  = bus.master_readdatavalid && (pending_reg != '0);
    assign drain_done = (state_reg == ST_DRAIN) && (pending_reg == '0) && (fifo_used == '0);

    assign bus.master_read       = read_req;
    assign bus.master_address    = addr_reg;
    assign bus.master_byteenable = '1;
    assign control_done          = zero_done_reg | drain_done;

    always_comb begin
        pending_next = pending_reg;
        if (accept && !rsp_valid) begin
            pending_next = pending_reg + PEND_ONE;
        end else if (rsp_valid && !accept) begin
            pending_next = pending_reg - PEND_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            pending_reg   <= '0;
            zero_done_reg <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            zero_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (control_go) begin
                        addr_reg      <= control_read_base;
                        remaining_reg <= control_read_length;
                        if (control_read_length != '0) begin
                            state_reg <= ST_READ;
                        end else begin
                            zero_done_reg <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (accept) begin
                        remaining_reg <= remaining_reg - BPW_STEP;
                        addr_reg      <= addr_reg + addr_step;
                        if (remaining_reg == BPW_STEP) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    rmst_sync_fifo #(
        .DW    (XDW),
        .DEPTH (FIFO_DEPTH),
        .AW    (FAW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (rsp_valid),
        .wr_data   (bus.master_readdata),
        .rd_en     (user_read_buffer),
        .rd_data   (user_buffer_data),
        .not_empty (user_data_available),
        .used      (fifo_used)
    );

endmodule

// File: tb/tb_avalon_read_master.sv
// Randomised bench for avalon_read_master: a slave model with random stalls
// and latency, a random consumer, and a word-list reference for each transfer.
module tb_avalon_read_master;
    localparam int XAW   = 32;
    localparam int XDW   = 128;
    localparam int BPW   = 16;
    localparam int DEPTH = 32;

    typedef struct {
        int             due;
        logic [XDW-1:0] data;
    } resp_t;

    logic           clk;
    logic           rst;
    logic           control_fixed_location;
    logic [XAW-1:0] control_read_base;
    logic [XAW-1:0] control_read_length;
    logic           control_go;
    logic           control_done;
    logic           user_read_buffer;
    logic [XDW-1:0] user_buffer_data;
    logic           user_data_available;

    avalon_read_master_if #(.XAW(XAW), .XDW(XDW)) bus ();

    avalon_read_master #(
        .XAW(XAW), .XDW(XDW), .FIFO_DEPTH(DEPTH), .FAW(5)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .control_fixed_location (control_fixed_location),
        .control_read_base      (control_read_base),
        .control_read_length    (control_read_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_read_buffer       (user_read_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_data_available    (user_data_available),
        .bus                    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transfer model and scoreboard state
    logic [XAW-1:0] base_m;
    int  n_words;
    bit  fixed_m;
    int  acc_cnt, pop_cnt, done_cnt;
    int  go_cyc, last_pop_cyc, cyc;
    int  acc_cyc [8];
    int  last_due;
    resp_t rq [$];

    // Slave / consumer behaviour knobs
    int wait_pct, lat_lo, lat_hi, pop_pct, hold_idx, hold_left;
    bit pop_single;

    task automatic check(input string tag, input logic [XDW-1:0] got, input logic [XDW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XDW-1:0] make_word(input logic [XAW-1:0] a, input int idx);
        logic [31:0] i32;
        i32 = idx;
        return {a, ~a, i32, i32 ^ 32'hA5A5_5A5A};
    endfunction

    function automatic logic [XAW-1:0] exp_addr(input int i);
        logic [XAW-1:0] off;
        off = fixed_m ? '0 : XAW'(i) * XAW'(BPW);
        return base_m + off;
    endfunction

    // Slave and consumer act on the falling edge; everything they drive holds
    // across the following rising edge.
    initial begin : bus_and_user
        bit acc, do_pop;
        int due;
        bus.master_readdatavalid = 1'b0;
        bus.master_waitrequest   = 1'b0;
        bus.master_readdata      = '0;
        user_read_buffer         = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rq.delete();
                last_due = 0;
                bus.master_readdatavalid = 1'b0;
                bus.master_waitrequest   = 1'b0;
                user_read_buffer         = 1'b0;
                continue;
            end
            if (control_go) go_cyc = cyc;

            if (hold_left > 0 && bus.master_read && acc_cnt == hold_idx) begin
                bus.master_waitrequest = 1'b1;
                hold_left--;
            end else begin
                bus.master_waitrequest = ($urandom_range(99) < wait_pct);
            end

            acc = bus.master_read && !bus.master_waitrequest;
            if (bus.master_read) check("addr", bus.master_address, exp_addr(acc_cnt));
            if (acc) begin
                check("read_in_range", acc_cnt < n_words, 1);
                check("credit", (acc_cnt - pop_cnt) < DEPTH, 1);
                if (acc_cnt < 8) acc_cyc[acc_cnt] = cyc;
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rq.push_back('{due, make_word(bus.master_address, acc_cnt)});
                acc_cnt++;
            end

            if (rq.size() > 0 && rq[0].due <= cyc) begin
                bus.master_readdatavalid = 1'b1;
                bus.master_readdata      = rq[0].data;
                void'(rq.pop_front());
            end else begin
                bus.master_readdatavalid = 1'b0;
                bus.master_readdata      = {$urandom, $urandom, $urandom, $urandom};
            end

            if (control_done) begin
                done_cnt++;
                check("done_pops", pop_cnt, n_words);
                if (n_words == 0) check("done_time_zero", cyc, go_cyc + 1);
                else              check("done_time", cyc, last_pop_cyc + 1);
            end

            do_pop = user_data_available && (pop_single || ($urandom_range(99) < pop_pct));
            if (pop_single && user_data_available) pop_single = 1'b0;
            user_read_buffer = do_pop || (!user_data_available && $urandom_range(3) == 0);
            if (do_pop) begin
                check("data", user_buffer_data, make_word(exp_addr(pop_cnt), pop_cnt));
                if (pop_cnt == n_words - 1) last_pop_cyc = cyc;
                pop_cnt++;
            end
        end
    end

    task automatic start(input logic [XAW-1:0] base, input int words, input bit fixed);
        @(posedge clk); #2;
        base_m   = base;
        n_words  = words;
`ifdef RMST_FIXED_LOCATION_EN
        fixed_m  = fixed;
`else
        fixed_m  = 1'b0;
`endif
        acc_cnt = 0; pop_cnt = 0; done_cnt = 0;
        go_cyc = -100; last_pop_cyc = -100;
        control_read_base      = base;
        control_read_length    = XAW'(words * BPW);
        control_fixed_location = fixed;
        control_go             = 1'b1;
        @(posedge clk); #2;
        control_go = 1'b0;
    endtask

    task automatic finish_xfer(input int budget);
        int i;
        for (i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        #2;
        if (done_cnt == 0) check("timeout", 0, 1);
        repeat (3) @(posedge clk);
        #2;
        check("done_once", done_cnt, 1);
        check("reads", acc_cnt, n_words);
        check("pops", pop_cnt, n_words);
        $display("xfer base=%08h words=%0d fixed=%0d reads=%0d pops=%0d dones=%0d",
                 base_m, n_words, fixed_m, acc_cnt, pop_cnt, done_cnt);
    endtask

    task automatic check_reset_outputs();
        check("rst_read", bus.master_read, 0);
        check("rst_addr", bus.master_address, 0);
        check("rst_done", control_done, 0);
        check("rst_avail", user_data_available, 0);
        check("rst_data", user_buffer_data, 0);
        check("rst_be", bus.master_byteenable, 16'hFFFF);
    endtask

    initial begin : main
        rst = 1'b1;
        control_go = 1'b0; control_fixed_location = 1'b0;
        control_read_base = '0; control_read_length = '0;
        wait_pct = 0; lat_lo = 2; lat_hi = 2; pop_pct = 100;
        hold_idx = 0; hold_left = 0; pop_single = 1'b0;
        n_words = 0; base_m = '0; fixed_m = 1'b0; cyc = 0; last_due = 0;
        #3;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Four back-to-back reads, fixed latency of 2
        start(32'h0000_1000, 4, 1'b0);
        finish_xfer(200);
        check("issue_start", acc_cyc[0], go_cyc + 1);
        for (int k = 1; k < 4; k++) check("issue_b2b", acc_cyc[k], acc_cyc[0] + k);

        // Zero length
        start(32'h0000_5000, 0, 1'b0);
        finish_xfer(50);

        // Stall the second read for 5 cycles
        hold_idx = 1; hold_left = 5;
        start(32'h0000_1000, 4, 1'b0);
        finish_xfer(200);
        check("hold_used", hold_left, 0);

        // Consumer stalled: issue must stop at FIFO depth, then follow pops
        pop_pct = 0; lat_lo = 1; lat_hi = 1;
        start(32'h0000_2000, 64, 1'b0);
        repeat (60) @(posedge clk);
        #2;
        check("credit_stop", acc_cnt, DEPTH);
        check("credit_read_low", bus.master_read, 0);
        for (int k = 0; k < 3; k++) begin
            pop_single = 1'b1;
            repeat (4) @(posedge clk);
            #2;
            check("credit_resume", acc_cnt, DEPTH + 1 + k);
        end
        pop_pct = 100;
        finish_xfer(500);

        // Fixed-location request (honoured only when the feature is built in)
        lat_lo = 1; lat_hi = 4; wait_pct = 20;
        start(32'h0000_3000, 3, 1'b1);
        finish_xfer(200);

        // Address wraps past the top of the address space
        start(32'hFFFF_FFC0, 8, 1'b0);
        finish_xfer(300);

        // Reset in the middle of a transfer
        wait_pct = 30; pop_pct = 50;
        start(32'h0000_4000, 16, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check_reset_outputs();
        start(32'h0000_6000, 16, 1'b0);
        finish_xfer(1000);

        // Random transfers
        for (int t = 0; t < 10; t++) begin
            wait_pct = $urandom_range(50);
            lat_lo   = $urandom_range(3, 1);
            lat_hi   = lat_lo + $urandom_range(4);
            pop_pct  = $urandom_range(100, 20);
            start($urandom & 32'hFFFF_FFF0, $urandom_range(40), 1'($urandom_range(1)));
            finish_xfer(3000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
